// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one serial transmitter between N_REQ byte producers.
// Launches a frame with a one-cycle ready pulse, then blocks for a fixed frame time.
module uart_tx_scheduler #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 160,
    parameter int CNT_W        = $clog2(FRAME_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_req_data,
    input  logic [N_REQ-1:0]     i_req_last,
    output logic [N_REQ-1:0]     o_req_ack,
    output logic [N_REQ-1:0]     o_grant,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_busy
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               lock_q, lock_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_ready_q, tx_ready_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;

    logic [7:0]         req_byte [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_byte
            assign req_byte[gi] = i_req_data[8*gi +: 8];
        end
    endgenerate

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   win_next;
    int                 idx;

    // A locked owner that still requests wins outright; otherwise rotate from ptr.
    always_comb begin
        found = 1'b0;
        win   = owner_q;
        cand  = '0;
        idx   = 0;
        if (lock_q && i_req[owner_q]) begin
            found = 1'b1;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                cand = PTR_W'(idx);
                if (!found && i_req[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
        win_next = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_ready_d = 1'b0;
        ack_d      = '0;
        grant_d    = grant_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_LAUNCH;
                    tx_data_d   = req_byte[win];
                    tx_ready_d  = 1'b1;
                    ack_d[win]  = 1'b1;
                    grant_d     = '0;
                    grant_d[win] = 1'b1;
                    owner_d     = win;
                    cnt_d       = CNT_W'(FRAME_CYCLES - 1);
                    if (i_req_last[win]) begin
                        lock_d = 1'b0;
                        ptr_d  = win_next;
                    end else begin
                        lock_d = 1'b1;
                    end
                end else if (lock_q) begin
                    // Owner abandoned its burst and nobody else is waiting.
                    lock_d  = 1'b0;
                    grant_d = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (!lock_q) begin
                        grant_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_q     <= 1'b0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_ready_q <= 1'b0;
            ack_q      <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
            ack_q      <= ack_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end

    assign o_req_ack  = ack_q;
    assign o_grant    = grant_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_ready = tx_ready_q;
    assign o_busy     = busy_q;
endmodule
